// File: rtl/gate_test_sequencer_pkg.sv
// gate_test_pkg: shared types and constants for the gate bank built-in test.
//   state_e       - sequencer FSM states
//   NUM_GATE_OUT  - width of the gate bank output vector
//   *_BIT         - bit position of each gate inside gate_out / fail_mask
//   VEC_LAST      - index of the final (a, b) vector in a sweep
//   golden_vec()  - truth-table reference for one (a, b) pair
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int NUM_GATE_OUT = 7;
  localparam int AND_BIT      = 6;
  localparam int OR_BIT       = 5;
  localparam int NAND_BIT     = 4;
  localparam int NOR_BIT      = 3;
  localparam int XOR_BIT      = 2;
  localparam int XNOR_BIT     = 1;
  localparam int NOT_BIT      = 0;

  localparam logic [1:0] VEC_LAST = 2'd3;
  localparam int         CNT_W    = 4;

  // Expected gate bank response for inputs a, b in gate_out bit order.
  function automatic logic [NUM_GATE_OUT-1:0] golden_vec(input logic a, input logic b);
    logic [NUM_GATE_OUT-1:0] v;
    v           = {NUM_GATE_OUT{1'b0}};
    v[AND_BIT]  = a & b;
    v[OR_BIT]   = a | b;
    v[NAND_BIT] = ~(a & b);
    v[NOR_BIT]  = ~(a | b);
    v[XOR_BIT]  = a ^ b;
    v[XNOR_BIT] = ~(a ^ b);
    v[NOT_BIT]  = ~a;
    return v;
  endfunction

endpackage

// File: rtl/gate_test_sequencer_if.sv
// gate_test_sequencer_if: all non-clock signals between the sequencer, the
// gate bank and the controlling logic.
//   start      - begin a sweep (controller -> sequencer)
//   gate_a/b   - gate bank stimulus (sequencer -> bank)
//   gate_out   - gate bank response (bank -> sequencer)
//   busy, done, pass, err_count, fail_mask, vec_idx - status (sequencer -> controller)
// Modport slave is the sequencer's view; master is the environment's view.
interface gate_test_sequencer_if;
  import gate_test_pkg::*;

  logic                    start;
  logic                    gate_a;
  logic                    gate_b;
  logic [NUM_GATE_OUT-1:0] gate_out;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic [2:0]              err_count;
  logic [NUM_GATE_OUT-1:0] fail_mask;
  logic [1:0]              vec_idx;

  modport slave (
    input  start, gate_out,
    output gate_a, gate_b, busy, done, pass, err_count, fail_mask, vec_idx
  );

  modport master (
    output start, gate_out,
    input  gate_a, gate_b, busy, done, pass, err_count, fail_mask, vec_idx
  );

endinterface

// File: rtl/gate_test_sequencer_golden.sv
// gate_test_golden: combinational truth-table reference for the gate bank.
//   a, b      - current stimulus
//   expected  - expected gate_out for (a, b), bit 6 = and ... bit 0 = not
module gate_test_golden
  import gate_test_pkg::*;
(
  input  logic                    a,
  input  logic                    b,
  output logic [NUM_GATE_OUT-1:0] expected
);

  assign expected = golden_vec(a, b);

endmodule

// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer: built-in sweep test for the basic gate bank.
// On an accepted start it walks (a, b) through 00, 01, 10, 11, holds each
// vector SETTLE_CYCLES cycles, samples gate_out in a one-cycle CHECK state and
// accumulates a mismatch count, sticky per-gate fail mask and a pass flag.
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   bus    - gate_test_sequencer_if.slave (start, gate_a/b, gate_out, status)
// Parameter SETTLE_CYCLES: 1..15 cycles between driving a vector and checking.
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gate_test_sequencer_if.slave  bus
);

  // Counter runs SETTLE_CYCLES-1 down to 0, so SETTLE lasts SETTLE_CYCLES cycles.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e                  state_r, state_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [1:0]              vec_idx_r, vec_idx_s;
  logic                    gate_a_r, gate_a_s;
  logic                    gate_b_r, gate_b_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic                    pass_r, pass_s;
  logic [2:0]              err_count_r, err_count_s;
  logic [NUM_GATE_OUT-1:0] fail_mask_r, fail_mask_s;
  logic [NUM_GATE_OUT-1:0] expected_s;
  logic [NUM_GATE_OUT-1:0] mismatch_s;

  gate_test_golden u_golden (
    .a        (gate_a_r),
    .b        (gate_b_r),
    .expected (expected_s)
  );

  assign mismatch_s = bus.gate_out ^ expected_s;

  // Next-state and next-output logic; every register holds unless a state says otherwise.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    vec_idx_s   = vec_idx_r;
    gate_a_s    = gate_a_r;
    gate_b_s    = gate_b_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    pass_s      = pass_r;
    err_count_s = err_count_r;
    fail_mask_s = fail_mask_r;

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s     = SETTLE;
          cnt_s       = SETTLE_LOAD;
          vec_idx_s   = 2'd0;
          gate_a_s    = 1'b0;
          gate_b_s    = 1'b0;
          busy_s      = 1'b1;
          pass_s      = 1'b0;
          err_count_s = 3'd0;
          fail_mask_s = {NUM_GATE_OUT{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end

      SETTLE: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = CHECK;
        end else begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      CHECK: begin
        fail_mask_s = fail_mask_r | mismatch_s;
        if (|mismatch_s) begin
          err_count_s = err_count_r + 3'd1;
        end else begin
          err_count_s = err_count_r;
        end
        if (vec_idx_r == VEC_LAST) begin
          // Registers update on the edge into DONE so results are final with done.
          state_s = DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (err_count_s == 3'd0);
        end else begin
          state_s   = SETTLE;
          vec_idx_s = vec_idx_r + 2'd1;
          gate_a_s  = vec_idx_s[1];
          gate_b_s  = vec_idx_s[0];
          cnt_s     = SETTLE_LOAD;
        end
      end

      DONE: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      vec_idx_r   <= 2'd0;
      gate_a_r    <= 1'b0;
      gate_b_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      err_count_r <= 3'd0;
      fail_mask_r <= {NUM_GATE_OUT{1'b0}};
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      vec_idx_r   <= vec_idx_s;
      gate_a_r    <= gate_a_s;
      gate_b_r    <= gate_b_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      pass_r      <= pass_s;
      err_count_r <= err_count_s;
      fail_mask_r <= fail_mask_s;
    end
  end

  assign bus.gate_a    = gate_a_r;
  assign bus.gate_b    = gate_b_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.err_count = err_count_r;
  assign bus.fail_mask = fail_mask_r;
  assign bus.vec_idx   = vec_idx_r;

endmodule
